// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states, lane helpers and idle-bus constants for rom_sdram_loader
package loader_pkg;

   function automatic int bpw_of(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int lane_w_of(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

   typedef enum logic [2:0] {
      S_INIT_WAIT,
      S_STABILIZE,
      S_FETCH,
      S_WRITE,
`ifdef ROM_SDRAM_LOADER_VERIFY_EN
      S_VERIFY,
      S_VERIFY_WAIT,
`endif
      S_DONE,
      S_ERROR
   } state_e;

   localparam logic IDLE_CS   = 1'b0;
   localparam logic IDLE_WR_N = 1'b1;
   localparam logic IDLE_RD_N = 1'b1;

endpackage

// File: rtl/rom_sdram_loader_if.sv
// rtl/rom_sdram_loader_if.sv - Avalon-style SDRAM controller slave bus
interface rom_sdram_loader_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0]   az_addr;
   logic [DATA_W/8-1:0] az_be_n;
   logic                az_cs;
   logic [DATA_W-1:0]   az_data;
   logic                az_rd_n;
   logic                az_wr_n;
   logic [DATA_W-1:0]   za_data;
   logic                za_valid;
   logic                za_waitrequest;

   modport master (
      output az_addr, az_be_n, az_cs, az_data, az_rd_n, az_wr_n,
      input  za_data, za_valid, za_waitrequest
   );

   modport slave (
      input  az_addr, az_be_n, az_cs, az_data, az_rd_n, az_wr_n,
      output za_data, za_valid, za_waitrequest
   );
endinterface

// File: rtl/loader_byte_packer.sv
// rtl/loader_byte_packer.sv - little-endian byte-to-word packer with active-low lane enables
module loader_byte_packer
   import loader_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load_i,
   input  logic                clear_i,
   input  logic [7:0]          byte_i,
   output logic [DATA_W-1:0]   data_o,
   output logic [DATA_W/8-1:0] be_n_o,
   output logic                last_lane_o,
   output logic                empty_o
);
   localparam int BPW = bpw_of(DATA_W);
   localparam int LW  = lane_w_of(BPW);

   logic [LW-1:0]     lane_q, lane_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [BPW-1:0]    be_n_q, be_n_d;

   assign last_lane_o = (lane_q == LW'(BPW - 1));
   assign empty_o     = &be_n_q;
   assign data_o      = data_q;
   assign be_n_o      = be_n_q;

   // be_n tracks filled lanes separately because lane wraps to 0 on a full word
   always_comb begin
      lane_d = lane_q;
      data_d = data_q;
      be_n_d = be_n_q;
      if (clear_i) begin
         lane_d = '0;
         data_d = '0;
         be_n_d = '1;
      end else if (load_i) begin
         data_d[lane_q*8 +: 8] = byte_i;
         be_n_d[lane_q]        = 1'b0;
         lane_d                = last_lane_o ? '0 : lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lane_q <= '0;
         data_q <= '0;
         be_n_q <= '1;
      end else begin
         lane_q <= lane_d;
         data_q <= data_d;
         be_n_q <= be_n_d;
      end
   end
endmodule

// File: rtl/rom_sdram_loader.sv
// rtl/rom_sdram_loader.sv - boot copy of program ROM into SDRAM; ROM_SDRAM_LOADER_VERIFY_EN adds read-back check
module rom_sdram_loader
   import loader_pkg::*;
#(
   parameter int ROM_ADDR_WIDTH   = 32,
   parameter int SDRAM_ADDR_WIDTH = 22,
   parameter int SDRAM_DATA_WIDTH = 16,
   parameter int BASE_ADDR        = 0,
   parameter int LOAD_BYTES       = 4096,
   parameter int STABLE_CYCLES    = 20
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        init_done,
   output logic [ROM_ADDR_WIDTH-1:0]   rom_address,
   input  logic [7:0]                  rom_byte,
   input  logic                        rom_done,
   rom_sdram_loader_if.master          sdram,
   output logic                        done,
   output logic                        error,
   output logic [SDRAM_ADDR_WIDTH-1:0] words_written
);
   localparam int BPW = bpw_of(SDRAM_DATA_WIDTH);
   localparam int CW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0]               STAB_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [ROM_ADDR_WIDTH-1:0]   LIMIT     = ROM_ADDR_WIDTH'(LOAD_BYTES);
   localparam logic [SDRAM_ADDR_WIDTH-1:0] BASE      = SDRAM_ADDR_WIDTH'(BASE_ADDR);

   state_e                      state_q, state_d;
   logic [CW-1:0]               stab_q, stab_d;
   logic [ROM_ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
   logic [SDRAM_ADDR_WIDTH-1:0] ww_q, ww_d;

   logic                        pk_load, pk_clear, pk_last, pk_empty;
   logic [SDRAM_DATA_WIDTH-1:0] pk_data;
   logic [BPW-1:0]              pk_be_n;

   logic                        cs, wr_n, rd_n;
   logic [BPW-1:0]              be_n;
   logic [SDRAM_DATA_WIDTH-1:0] wdata;
   logic [SDRAM_ADDR_WIDTH-1:0] addr;
   logic                        term;

   loader_byte_packer #(.DATA_W(SDRAM_DATA_WIDTH)) u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (pk_load),
      .clear_i     (pk_clear),
      .byte_i      (rom_byte),
      .data_o      (pk_data),
      .be_n_o      (pk_be_n),
      .last_lane_o (pk_last),
      .empty_o     (pk_empty)
   );

   assign term = rom_done || (rom_addr_q == LIMIT);

`ifdef ROM_SDRAM_LOADER_VERIFY_EN
   logic [SDRAM_DATA_WIDTH-1:0] lane_mask;
   logic                        mismatch;

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < BPW; i++) begin
         lane_mask[i*8 +: 8] = {8{~pk_be_n[i]}};
      end
   end
   assign mismatch = ((sdram.za_data ^ pk_data) & lane_mask) != '0;
`else
   logic unused_verify_inputs;
   assign unused_verify_inputs = ^{sdram.za_data, sdram.za_valid};
`endif

   always_comb begin
      state_d    = state_q;
      stab_d     = stab_q;
      rom_addr_d = rom_addr_q;
      ww_d       = ww_q;
      pk_load    = 1'b0;
      pk_clear   = 1'b0;
      cs         = IDLE_CS;
      wr_n       = IDLE_WR_N;
      rd_n       = IDLE_RD_N;
      be_n       = '1;
      wdata      = '0;
      addr       = '0;
      case (state_q)
         S_INIT_WAIT: begin
            if (init_done) begin
               state_d = S_STABILIZE;
               stab_d  = '0;
            end
         end
         S_STABILIZE: begin
            if (init_done) begin
               if (stab_q == STAB_LAST) state_d = S_FETCH;
               else                     stab_d  = stab_q + 1'b1;
            end
         end
         S_FETCH: begin
            if (term) begin
               state_d = pk_empty ? S_DONE : S_WRITE;
            end else begin
               pk_load    = 1'b1;
               rom_addr_d = rom_addr_q + 1'b1;
               if (pk_last) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            cs    = 1'b1;
            wr_n  = 1'b0;
            addr  = BASE + ww_q;
            wdata = pk_data;
            be_n  = pk_be_n;
            if (!sdram.za_waitrequest) begin
               ww_d = ww_q + 1'b1;
`ifdef ROM_SDRAM_LOADER_VERIFY_EN
               state_d = S_VERIFY;
`else
               pk_clear = 1'b1;
               state_d  = S_FETCH;
`endif
            end
         end
`ifdef ROM_SDRAM_LOADER_VERIFY_EN
         // packer keeps the written word until the read-back has been compared
         S_VERIFY: begin
            cs   = 1'b1;
            rd_n = 1'b0;
            addr = BASE + ww_q - 1'b1;
            be_n = pk_be_n;
            if (!sdram.za_waitrequest) state_d = S_VERIFY_WAIT;
         end
         S_VERIFY_WAIT: begin
            if (sdram.za_valid) begin
               pk_clear = 1'b1;
               if (mismatch)  state_d = S_ERROR;
               else if (term) state_d = S_DONE;
               else           state_d = S_FETCH;
            end
         end
`endif
         S_DONE:  ;
         S_ERROR: ;
         default: state_d = S_INIT_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_INIT_WAIT;
         stab_q     <= '0;
         rom_addr_q <= '0;
         ww_q       <= '0;
      end else begin
         state_q    <= state_d;
         stab_q     <= stab_d;
         rom_addr_q <= rom_addr_d;
         ww_q       <= ww_d;
      end
   end

   assign sdram.az_cs   = cs;
   assign sdram.az_wr_n = wr_n;
   assign sdram.az_rd_n = rd_n;
   assign sdram.az_be_n = be_n;
   assign sdram.az_data = wdata;
   assign sdram.az_addr = addr;
   assign rom_address   = rom_addr_q;
   assign words_written = ww_q;
   assign done          = (state_q == S_DONE);
`ifdef ROM_SDRAM_LOADER_VERIFY_EN
   assign error = (state_q == S_ERROR);
`else
   assign error = 1'b0;
`endif
endmodule

// File: tb/tb_rom_sdram_loader.sv
// tb/tb_rom_sdram_loader.sv - directed bench for rom_sdram_loader (default build)
module tb_rom_sdram_loader;
   import loader_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        init_done;

   logic [31:0] rom_address_a, rom_address_b;
   logic [7:0]  rom_byte_a, rom_byte_b;
   logic        rom_done_a, rom_done_b;
   logic        done_a, done_b, error_a, error_b;
   logic [21:0] words_a, words_b;

   logic [7:0]  rom_a [16];
   logic [7:0]  rom_b [16];
   int          len_a, len_b;

   int passed = 0;
   int total  = 0;

   rom_sdram_loader_if #(.ADDR_W(22), .DATA_W(16)) bus_a ();
   rom_sdram_loader_if #(.ADDR_W(22), .DATA_W(16)) bus_b ();

   rom_sdram_loader #(
      .ROM_ADDR_WIDTH(32), .SDRAM_ADDR_WIDTH(22), .SDRAM_DATA_WIDTH(16),
      .BASE_ADDR(32'h100), .LOAD_BYTES(4096), .STABLE_CYCLES(4)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .init_done(init_done),
      .rom_address(rom_address_a), .rom_byte(rom_byte_a), .rom_done(rom_done_a),
      .sdram(bus_a), .done(done_a), .error(error_a), .words_written(words_a)
   );

   rom_sdram_loader #(
      .ROM_ADDR_WIDTH(32), .SDRAM_ADDR_WIDTH(22), .SDRAM_DATA_WIDTH(16),
      .BASE_ADDR(0), .LOAD_BYTES(2), .STABLE_CYCLES(4)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .init_done(init_done),
      .rom_address(rom_address_b), .rom_byte(rom_byte_b), .rom_done(rom_done_b),
      .sdram(bus_b), .done(done_b), .error(error_b), .words_written(words_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rom_byte_a = (rom_address_a < 32'(len_a)) ? rom_a[rom_address_a[3:0]] : 8'h00;
      rom_done_a = (rom_address_a >= 32'(len_a));
      rom_byte_b = (rom_address_b < 32'(len_b)) ? rom_b[rom_address_b[3:0]] : 8'h00;
      rom_done_b = (rom_address_b >= 32'(len_b));
   end

   // accepted-write logs
   logic [21:0] wa_addr [8];
   logic [15:0] wa_data [8];
   logic [1:0]  wa_be   [8];
   logic [3:0]  na;
   logic [15:0] wb_data [8];
   logic [3:0]  nb;

   always @(posedge clk) begin
      if (!reset_n) begin
         na <= 4'd0;
         nb <= 4'd0;
      end else begin
         if (bus_a.az_cs && !bus_a.az_wr_n && !bus_a.za_waitrequest && na < 4'd8) begin
            wa_addr[na[2:0]] <= bus_a.az_addr;
            wa_data[na[2:0]] <= bus_a.az_data;
            wa_be[na[2:0]]   <= bus_a.az_be_n;
            na <= na + 4'd1;
         end
         if (bus_b.az_cs && !bus_b.az_wr_n && !bus_b.za_waitrequest && nb < 4'd8) begin
            wb_data[nb[2:0]] <= bus_b.az_data;
            nb <= nb + 4'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_done_a(input string tag);
      int n = 0;
      while (!done_a && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done_a), 32'd1);
   endtask

   task automatic wait_write_a(input string tag);
      int n = 0;
      while (bus_a.az_wr_n && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(bus_a.az_wr_n), 32'd0);
   endtask

   logic [21:0] cap_addr;
   logic [15:0] cap_data;

   initial begin
      reset_n   = 1'b0;
      init_done = 1'b0;
      bus_a.za_data = '0; bus_a.za_valid = 1'b0; bus_a.za_waitrequest = 1'b0;
      bus_b.za_data = '0; bus_b.za_valid = 1'b0; bus_b.za_waitrequest = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rom_a[i] = 8'h00;
         rom_b[i] = 8'(i + 1);
      end
      rom_a[0] = 8'h11; rom_a[1] = 8'h22; rom_a[2] = 8'h33; rom_a[3] = 8'h44;
      len_a = 4;
      len_b = 6;

      repeat (2) @(negedge clk);
      chk("rst_cs",    32'(bus_a.az_cs),   32'd0);
      chk("rst_wr_n",  32'(bus_a.az_wr_n), 32'd1);
      chk("rst_rd_n",  32'(bus_a.az_rd_n), 32'd1);
      chk("rst_be_n",  32'(bus_a.az_be_n), 32'h3);
      chk("rst_addr",  rom_address_a,      32'd0);
      chk("rst_words", 32'(words_a),       32'd0);
      chk("rst_done",  32'(done_a),        32'd0);
      chk("rst_error", 32'(error_a),       32'd0);

      reset_n = 1'b1;
      @(negedge clk);
      chk("init_wait_hold", rom_address_a, 32'd0);
      init_done = 1'b1;
      repeat (5) @(negedge clk);
      chk("stab_no_inc", rom_address_a, 32'd0);
      @(negedge clk);
      chk("first_inc", rom_address_a, 32'd1);

      // 4-byte image, zero-wait
      wait_done_a("t1_done");
      chk("t1_nwr",   32'(na),         32'd2);
      chk("t1_a0",    32'(wa_addr[0]), 32'h100);
      chk("t1_d0",    32'(wa_data[0]), 32'h2211);
      chk("t1_be0",   32'(wa_be[0]),   32'h0);
      chk("t1_a1",    32'(wa_addr[1]), 32'h101);
      chk("t1_d1",    32'(wa_data[1]), 32'h4433);
      chk("t1_be1",   32'(wa_be[1]),   32'h0);
      chk("t1_words", 32'(words_a),    32'd2);
      chk("t1_error", 32'(error_a),    32'd0);
      chk("t1_idle_cs",   32'(bus_a.az_cs),   32'd0);
      chk("t1_idle_wr_n", 32'(bus_a.az_wr_n), 32'd1);
      chk("t1_idle_be_n", 32'(bus_a.az_be_n), 32'h3);

      // LOAD_BYTES=2 instance with a 6-byte image
      chk("lim_done",  32'(done_b),     32'd1);
      chk("lim_nwr",   32'(nb),         32'd1);
      chk("lim_d0",    32'(wb_data[0]), 32'h0201);
      chk("lim_addr",  rom_address_b,   32'd2);
      chk("lim_words", 32'(words_b),    32'd1);

      // 3-byte image: partial final word
      rom_a[0] = 8'hAA; rom_a[1] = 8'hBB; rom_a[2] = 8'hCC;
      len_a = 3;
      do_reset();
      wait_done_a("t2_done");
      chk("t2_nwr",  32'(na),         32'd2);
      chk("t2_d0",   32'(wa_data[0]), 32'hBBAA);
      chk("t2_be0",  32'(wa_be[0]),   32'h0);
      chk("t2_d1",   32'(wa_data[1]), 32'h00CC);
      chk("t2_be1",  32'(wa_be[1]),   32'h2);
      chk("t2_a1",   32'(wa_addr[1]), 32'h101);
      chk("t2_addr", rom_address_a,   32'd3);

      // waitrequest held for 5 cycles of the first write
      rom_a[0] = 8'h11; rom_a[1] = 8'h22; rom_a[2] = 8'h33; rom_a[3] = 8'h44;
      len_a = 4;
      bus_a.za_waitrequest = 1'b1;
      do_reset();
      wait_write_a("t3_reach_write");
      cap_addr = bus_a.az_addr;
      cap_data = bus_a.az_data;
      chk("t3_cap_addr", 32'(cap_addr), 32'h100);
      chk("t3_cap_data", 32'(cap_data), 32'h2211);
      for (int i = 0; i < 5; i++) begin
         chk("t3_stall_hold", {9'd0, bus_a.az_wr_n, bus_a.az_addr},
             {9'd0, 1'b0, cap_addr});
         chk("t3_stall_data", 32'(bus_a.az_data), 32'(cap_data));
         chk("t3_stall_words", 32'(words_a), 32'd0);
         @(negedge clk);
      end
      bus_a.za_waitrequest = 1'b0;
      @(negedge clk);
      chk("t3_one_write", 32'(words_a), 32'd1);
      chk("t3_one_logged", 32'(na), 32'd1);
      wait_done_a("t3_done");
      chk("t3_words", 32'(words_a), 32'd2);

      // reset while a write is stalled
      bus_a.za_waitrequest = 1'b1;
      do_reset();
      wait_write_a("t4_reach_write");
      reset_n = 1'b0;
      @(negedge clk);
      chk("t4_cs",    32'(bus_a.az_cs),   32'd0);
      chk("t4_wr_n",  32'(bus_a.az_wr_n), 32'd1);
      chk("t4_rd_n",  32'(bus_a.az_rd_n), 32'd1);
      chk("t4_be_n",  32'(bus_a.az_be_n), 32'h3);
      chk("t4_data",  32'(bus_a.az_data), 32'd0);
      chk("t4_addr",  32'(bus_a.az_addr), 32'd0);
      chk("t4_rom",   rom_address_a,      32'd0);
      chk("t4_words", 32'(words_a),       32'd0);
      chk("t4_done",  32'(done_a),        32'd0);
      bus_a.za_waitrequest = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_done_a("t4_done_after");
      chk("t4_nwr", 32'(na),         32'd2);
      chk("t4_a0",  32'(wa_addr[0]), 32'h100);
      chk("t4_d0",  32'(wa_data[0]), 32'h2211);
      chk("t4_d1",  32'(wa_data[1]), 32'h4433);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
